// File: rtl/count_dir_pkg.sv
// count_dir_pkg: shared FSM and step encodings for count_dir_decoder
package count_dir_pkg;
  typedef enum logic [1:0] {EMPTY, PRIMED, UP, DOWN} state_e;
  typedef enum logic [1:0] {ST_UP, ST_DOWN, ST_HOLD, ST_ERR} step_e;
endpackage

// File: rtl/count_step_classify.sv
// count_step_classify: classifies a count change as up/down step, hold or illegal jump
module count_step_classify
  import count_dir_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] prev,
  output step_e            step
);
  logic [WIDTH-1:0] delta;
  // modular difference makes the 7->0 and 0->7 wraps legal single steps
  assign delta = q_in - prev;
  assign step  = (delta == WIDTH'(1)) ? ST_UP   :
                 (&delta)             ? ST_DOWN :
                 (~|delta)            ? ST_HOLD : ST_ERR;
endmodule

// File: rtl/count_dir_decoder.sv
// count_dir_decoder: recovers direction and run length from an observed up/down count bus.
// Define DIR_DEBOUNCE_EN to require two consecutive opposite steps before a direction flip.
module count_dir_decoder
  import count_dir_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int RUN_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] q_in,
  input  logic             sample_en,
  output logic             dir,
  output logic             dir_valid,
  output logic             dir_change,
  output logic             step_err,
  output logic             hold,
  output logic [RUN_W-1:0] run_len
);
  state_e           state_q, state_d;
  step_e            step;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             dir_q, dir_d, hold_q, hold_d, chg_q, chg_d, err_q, err_d;
  logic             mv, up_s;
`ifdef DIR_DEBOUNCE_EN
  logic             pend_q, pend_d;
`endif

  count_step_classify #(.WIDTH(WIDTH)) u_classify (
    .q_in (q_in),
    .prev (prev_q),
    .step (step)
  );

  assign mv   = (step == ST_UP) || (step == ST_DOWN);
  assign up_s = step == ST_UP;

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    dir_d   = dir_q;
    run_d   = run_q;
    hold_d  = hold_q;
    chg_d   = 1'b0;
    err_d   = 1'b0;
`ifdef DIR_DEBOUNCE_EN
    pend_d  = pend_q;
`endif
    if (sample_en) begin
      prev_d = q_in;
      hold_d = (state_q != EMPTY) && (step == ST_HOLD);
`ifdef DIR_DEBOUNCE_EN
      pend_d = 1'b0;
`endif
      case (state_q)
        EMPTY: state_d = PRIMED;
        PRIMED: begin
          err_d = step == ST_ERR;
          if (mv) begin
            state_d = up_s ? UP : DOWN;
            dir_d   = up_s;
            run_d   = RUN_W'(1);
          end
        end
        default: begin
          if (step == ST_ERR) begin
            state_d = PRIMED;
            err_d   = 1'b1;
            run_d   = '0;
          end else if (mv && (up_s == (state_q == UP))) begin
            run_d = (&run_q) ? run_q : run_q + RUN_W'(1);
          end else if (mv) begin
`ifdef DIR_DEBOUNCE_EN
            pend_d = !pend_q;
            if (pend_q) begin
              state_d = up_s ? UP : DOWN;
              dir_d   = up_s;
              chg_d   = 1'b1;
              run_d   = RUN_W'(2);
            end
`else
            state_d = up_s ? UP : DOWN;
            dir_d   = up_s;
            chg_d   = 1'b1;
            run_d   = RUN_W'(1);
`endif
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= EMPTY;
      prev_q  <= '0;
      dir_q   <= 1'b0;
      run_q   <= '0;
      hold_q  <= 1'b0;
      chg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      dir_q   <= dir_d;
      run_q   <= run_d;
      hold_q  <= hold_d;
      chg_q   <= chg_d;
      err_q   <= err_d;
    end
  end

`ifdef DIR_DEBOUNCE_EN
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) pend_q <= 1'b0;
    else pend_q <= pend_d;
  end
`endif

  assign dir        = dir_q;
  assign dir_valid  = (state_q == UP) || (state_q == DOWN);
  assign dir_change = chg_q;
  assign step_err   = err_q;
  assign hold       = hold_q;
  assign run_len    = run_q;
endmodule

// File: tb/tb_count_dir_decoder.sv
// tb_count_dir_decoder: scoreboard bench with an integer-level direction/run model.
// Define DIR_DEBOUNCE_EN here too when building the debounced variant.
module tb_count_dir_decoder;
  localparam int RUN_MAX = 255;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       sample_en = 1'b0;
  logic [2:0] q_in = '0;
  logic       dir, dir_valid, dir_change, step_err, hold;
  logic [7:0] run_len;

  typedef struct {
    int dir;
    int valid;
    int chg;
    int err;
    int hold;
    int run;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  bit m_primed, m_dir, m_hold, m_pend, m_chg, m_err;
  int m_prev, m_mode, m_run;

  always #5 clk = ~clk;

  count_dir_decoder #(.WIDTH(3), .RUN_W(8)) dut (
    .clk        (clk),
    .clear      (clear),
    .q_in       (q_in),
    .sample_en  (sample_en),
    .dir        (dir),
    .dir_valid  (dir_valid),
    .dir_change (dir_change),
    .step_err   (step_err),
    .hold       (hold),
    .run_len    (run_len)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare(input exp_t e);
    check("dir", int'(dir), e.dir);
    check("dir_valid", int'(dir_valid), e.valid);
    check("dir_change", int'(dir_change), e.chg);
    check("step_err", int'(step_err), e.err);
    check("hold", int'(hold), e.hold);
    check("run_len", int'(run_len), e.run);
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.dir   = int'(m_dir);
    e.valid = (m_mode != 0) ? 1 : 0;
    e.chg   = int'(m_chg);
    e.err   = int'(m_err);
    e.hold  = int'(m_hold);
    e.run   = m_run;
    return e;
  endfunction

  task automatic model_reset();
    m_primed = 0; m_dir = 0; m_hold = 0; m_pend = 0; m_chg = 0; m_err = 0;
    m_prev = 0; m_mode = 0; m_run = 0;
  endtask

  // m_mode: 0 = no direction known, +1 counting up, -1 counting down
  task automatic model_step(input bit en, input int q);
    int d, s;
    m_chg = 0;
    m_err = 0;
    if (!en) return;
    if (!m_primed) m_primed = 1;
    else begin
      d = (q - m_prev + 8) % 8;
      m_hold = (d == 0);
      if (d == 1 || d == 7) begin
        s = (d == 1) ? 1 : -1;
        if (m_mode == 0) begin
          m_mode = s; m_dir = (s > 0); m_run = 1; m_pend = 0;
        end else if (m_mode == s) begin
          m_run = (m_run < RUN_MAX) ? m_run + 1 : RUN_MAX; m_pend = 0;
        end
`ifdef DIR_DEBOUNCE_EN
        else if (!m_pend) m_pend = 1;
        else begin
          m_mode = s; m_dir = (s > 0); m_run = 2; m_chg = 1; m_pend = 0;
        end
`else
        else begin
          m_mode = s; m_dir = (s > 0); m_run = 1; m_chg = 1;
        end
`endif
      end else if (d != 0) begin
        m_err = 1; m_mode = 0; m_run = 0; m_pend = 0;
      end else m_pend = 0;
    end
    m_prev = q;
  endtask

  task automatic drive(input bit en, input int q);
    @(negedge clk);
    sample_en = en;
    q_in = q[2:0];
    model_step(en, q);
    sb.push_back(model_out());
  endtask

  task automatic seq(input int v[$]);
    foreach (v[i]) drive(1'b1, v[i]);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) check("scoreboard_drain", sb.size(), 0);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (sb.size() != 0) compare(sb.pop_front());
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s[$];
    int cur, r;
    bit en;
    model_reset();
    #22;
    compare(model_out());
    #1 clear = 1'b1;
    s = '{0, 1, 2, 3};       seq(s);
    s = '{6, 7, 0, 1};       seq(s);
    s = '{2, 1, 0, 7, 6};    seq(s);
`ifdef DIR_DEBOUNCE_EN
    s = '{3, 4, 3, 2};       seq(s);
`else
    s = '{3, 4, 3};          seq(s);
`endif
    s = '{1, 2, 5, 6};       seq(s);
    s = '{5, 5, 6, 6, 6, 7}; seq(s);
    drive(1'b0, 7);
    drive(1'b0, 3);
    s = '{4, 0, 1, 2, 3, 4, 5}; seq(s);
    drain();
    @(posedge clk);
    #2 clear = 1'b0;
    model_reset();
    #1 compare(model_out());
    #1 clear = 1'b1;
    s = '{4, 4, 5};          seq(s);
    for (int i = 6; i < 300; i++) drive(1'b1, i % 8);
    cur = 299 % 8;
    for (int i = 0; i < 2000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 9);
      if (en) cur = (r < 4) ? (cur + 1) % 8 : (r < 7) ? (cur + 7) % 8 :
                    (r < 8) ? cur : int'($urandom_range(0, 7));
      drive(en, cur);
    end
    drive(1'b0, cur);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
